ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Decoupled instruction-fetch front end between the instruction memory port and the IF/ID pipeline register.
- Generates sequential fetch addresses and issues requests over a req/gnt/rvalid handshake.
- Buffers returned (pc, instr) pairs in a small FIFO and presents them to ID with valid/ready.
- Flushes on a branch, jump or interrupt redirect coming from the MEM stage or the interrupt client.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  Clock. All state updates on the negedge, matching the pipeline registers.
- clr  in  1  Reset: asynchronous, active-low.
- redirect_valid  in  1  Taken branch, jump or interrupt entry. Asserted for one cycle.
- redirect_pc  in  32  New fetch address. Bits [1:0] are ignored and forced to 0.
- imem_req  out  1  Fetch request.
- imem_addr  out  32  Fetch address. Held stable while imem_req is high and imem_gnt is low.
- imem_gnt  in  1  Memory accepted the request this cycle.
- imem_rvalid  in  1  Read data valid for the oldest accepted request.
- imem_rdata  in  32  Instruction word.
- deq_valid  out  1  FIFO head is valid.
- deq_ready  in  1  ID accepts the head. Low when the ID stage is in PL_PAUSE.
- deq_pc  out  32  PC of the head entry.
- deq_instr  out  32  Instruction of the head entry.
- occupancy  out  $clog2(DEPTH)+1  Number of valid FIFO entries.

Behaviour:
- Reset (clr=0, asynchronous) sets:
  - fetch_pc=RESET_PC, FIFO empty, rd_ptr=wr_ptr=0, state=IDLE.
  - Outputs: imem_req=0, deq_valid=0, occupancy=0, deq_pc=0, deq_instr=0.
  - Reset mid-transaction abandons the outstanding request; a later rvalid arriving in IDLE is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request granted, data pending.
  - DROP: request granted before a redirect, so its data is stale.
- At most one request is outstanding.
- Request generation:
  - imem_req = (state==IDLE) && !redirect_valid && (occupancy < DEPTH).
  - imem_addr = fetch_pc.
- IDLE transitions:
  - On imem_req && imem_gnt: go to WAIT, latch req_pc=fetch_pc, fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - Otherwise stay in IDLE.
- WAIT transitions:
  - On imem_rvalid without redirect: push {req_pc, imem_rdata}, go to IDLE. A slot is guaranteed, because a request is issued only when occupancy < DEPTH and there is no other in-flight request.
  - On redirect_valid, with or without rvalid the same cycle: go to DROP if rvalid is absent, or to IDLE if rvalid is present (that data is discarded, not pushed).
- DROP transitions:
  - On imem_rvalid: discard the data, go to IDLE.
  - A redirect while in DROP only updates fetch_pc.
- Redirect, in any state:
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - FIFO flushed: occupancy=0, pointers reset.
  - deq_valid=0 in the following cycle.
  - Redirect has priority over a same-cycle push and a same-cycle dequeue; a dequeue in the redirect cycle is still considered consumed by ID.
- Dequeue:
  - deq_valid = (occupancy != 0).
  - deq_pc and deq_instr are driven combinationally from the head entry.
  - A pop occurs on deq_valid && deq_ready.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
  - Legal even when occupancy==DEPTH? No: a push never happens at DEPTH by construction.
  - Pop on an empty FIFO is impossible (deq_valid=0).
- Latency:
  - Minimum gnt-to-deq_valid is 2 edges: gnt edge to WAIT, then the rvalid edge pushes.
  - Throughput is one instruction per 2 cycles with single-cycle memory (one-outstanding limit).
- Pointer widths: $clog2(DEPTH) with natural wrap; occupancy is a separate counter.

Decomposition:
- Shared define header (alongside the existing PL_* defines):
  - FQ_IDLE, FQ_WAIT, FQ_DROP state encodings (2 bits).
  - IFQ_DEPTH default.
- One sub-module: ifq_fifo. Synchronous-write, combinational-read storage of 64-bit {pc, instr} entries, with push, pop, flush, occupancy and async active-low clr.
- The FSM and PC generation stay in ifetch_queue.

Test Plan:
- Reset, then single-cycle memory (gnt=1, rvalid the cycle after gnt), deq_ready=1, instr = address ^ 32'hA5A5_0000 -> imem_addr sequence 0,4,8,...; deq_pc/deq_instr pairs match in order; no gaps beyond the 2-cycle cadence.
- deq_ready=0 for 20 cycles -> occupancy saturates at 4 and imem_req drops. Then deq_ready=1 -> four entries PC 0x0..0xC drain in order and fetch resumes at 0x10.
- Redirect to 0x0000_0103 while WAIT (rvalid 3 cycles later) -> FIFO empties next cycle; the stale rvalid is discarded; next imem_addr=0x100; first deq_pc=0x100.
- redirect_valid in the same cycle as imem_rvalid -> data not pushed; state returns to IDLE; the next request goes to the redirect target.
- Randomised gnt/rvalid delays (0-5 cycles) with random deq_ready -> every dequeued pc is consecutive (+4) since the last redirect and deq_instr matches the memory model; no overflow.
- Assert clr while in WAIT, release, then deliver a late rvalid -> it is ignored; imem_addr=RESET_PC; occupancy=0.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package ifetch_queue_pkg;

  localparam int unsigned IFQ_DEPTH    = 4;
  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

  // Fetch FSM state encodings.
  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  // One buffered fetch result.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Small {pc, instr} FIFO: synchronous write, combinational read, flush wins over push/pop.
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ifq_entry_t               wdata,
  output ifq_entry_t               rdata,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  ifq_entry_t        mem [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PtrW:0]     count_q;
  logic              pop_eff;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign pop_eff   = pop && (count_q != '0);
  assign occupancy = count_q;
  // Empty FIFO reads as zero so the head outputs are clean after reset/flush.
  assign rdata     = (count_q != '0) ? mem[rd_ptr_q] : '0;

  // Entry storage, written on push unless a flush discards it.
  always_ff @(negedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy counter.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop_eff) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (!push && pop_eff) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch front end: sequential PC generation, one-outstanding memory
// handshake, and a small result FIFO towards ID. Flushes on redirect.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [31:0]            deq_pc,
  output logic [31:0]            deq_instr,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  fq_state_e   state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;
  logic        push;
  logic        pop;
  ifq_entry_t  wdata;
  ifq_entry_t  head;

  // Request only with no transfer in flight and a guaranteed free slot; gated
  // by clr so nothing is requested while reset is held.
  assign imem_req  = clr && (state_q == FQ_IDLE) && !redirect_valid &&
                     (occupancy < OccW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign push      = (state_q == FQ_WAIT) && imem_rvalid && !redirect_valid;
  assign deq_valid = (occupancy != '0);
  assign pop       = deq_valid && deq_ready;
  assign wdata     = '{pc: req_pc_q, instr: imem_rdata};
  assign deq_pc    = head.pc;
  assign deq_instr = head.instr;

  ifq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wdata    (wdata),
    .rdata    (head),
    .occupancy(occupancy)
  );

  // Fetch FSM and PC generation.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= FQ_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc_q <= word_align(redirect_pc);
      end else if (imem_req && imem_gnt) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
      unique case (state_q)
        FQ_IDLE: begin
          if (imem_req && imem_gnt) begin
            state_q  <= FQ_WAIT;
            req_pc_q <= fetch_pc_q;
          end
        end
        FQ_WAIT: begin
          // Redirect turns the in-flight word stale; if it lands now it is simply dropped.
          if (redirect_valid) begin
            state_q <= imem_rvalid ? FQ_IDLE : FQ_DROP;
          end else if (imem_rvalid) begin
            state_q <= FQ_IDLE;
          end
        end
        FQ_DROP: begin
          if (imem_rvalid) begin
            state_q <= FQ_IDLE;
          end
        end
        default: state_q <= FQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  ifetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_pc        (deq_pc),
    .deq_instr     (deq_instr),
    .occupancy     (occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected FIFO contents and fetch bookkeeping.
  logic [63:0] mq[$];
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_req_pc = 32'h0;
  bit          m_out = 0;
  bit          m_stale = 0;

  // Memory responder state.
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          p_gnt = 100, p_ready = 100, dly_min = 0, dly_max = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, check and advance model at posedge+3; DUT updates on negedge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    bit rv, gnt_b, rdy, req_exp, pop, granted;
    @(posedge clk);
    #1;
    rv    = mem_pend && (mem_cnt == 0);
    gnt_b = ($urandom_range(99) < p_gnt);
    rdy   = ($urandom_range(99) < p_ready);
    imem_gnt       = gnt_b;
    imem_rvalid    = rv;
    imem_rdata     = rv ? (mem_addr ^ KEY) : $urandom;
    redirect_valid = redir;
    redirect_pc    = rpc;
    deq_ready      = rdy;
    #2;
    req_exp = !m_out && !redir && (mq.size() < DEPTH);
    check("imem_req", imem_req, req_exp);
    if (req_exp) check("imem_addr", imem_addr, m_pc);
    check("occupancy", occupancy, mq.size());
    check("deq_valid", deq_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("deq_pc", deq_pc, mq[0][63:32]);
      check("deq_instr", deq_instr, mq[0][31:0]);
    end
    // Memory reacts to what the DUT actually requests.
    granted = imem_req && gnt_b;
    if (rv) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (granted) begin
      mem_pend = 1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(dly_max, dly_min);
    end
    // Model state after this negedge.
    pop = (mq.size() != 0) && rdy;
    if (redir) begin
      mq.delete();
      m_pc = rpc & ~32'h3;
      if (m_out) begin
        if (rv) begin
          m_out   = 0;
          m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_out && rv) begin
        if (!m_stale) mq.push_back({m_req_pc, m_req_pc ^ KEY});
        m_out   = 0;
        m_stale = 0;
      end
      if (req_exp && gnt_b) begin
        m_out    = 1;
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    deq_ready = 1'b0;
    #2;
    check("rst_req", imem_req, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_deq_pc", deq_pc, 0);
    check("rst_deq_instr", deq_instr, 0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    mq.delete();
    m_pc = 32'h0;
    m_out = 0;
    m_stale = 0;
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 50 && !m_out; i++) cycle(0, 0);
    if (!m_out) check(tag, 0, 1);
  endtask

  initial begin
    // Reset and single-cycle memory streaming.
    do_reset();
    p_gnt = 100; p_ready = 100; dly_min = 0; dly_max = 0;
    for (int i = 0; i < 30; i++) cycle(0, 0);

    // Back-pressure: FIFO saturates, then drains 0x0..0xC and fetch resumes at 0x10.
    do_reset();
    p_ready = 0;
    for (int i = 0; i < 20; i++) cycle(0, 0);
    #5;
    check("sat_occupancy", occupancy, DEPTH);
    check("sat_req", imem_req, 0);
    p_ready = 100;
    for (int i = 0; i < 16; i++) cycle(0, 0);

    // Redirect while waiting on a slow response.
    dly_min = 3; dly_max = 3;
    wait_outstanding("wait_redir_wait");
    cycle(1, 32'h0000_0103);
    dly_min = 0; dly_max = 0;
    for (int i = 0; i < 20; i++) cycle(0, 0);

    // Redirect in the same cycle as rvalid.
    dly_min = 2; dly_max = 2;
    wait_outstanding("wait_redir_rvalid");
    for (int i = 0; i < 10 && !(mem_pend && mem_cnt == 0); i++) cycle(0, 0);
    if (!(mem_pend && mem_cnt == 0)) check("wait_rvalid_slot", 0, 1);
    cycle(1, 32'h0000_0200);
    for (int i = 0; i < 10; i++) cycle(0, 0);

    // Randomised delays, back-pressure and redirects.
    p_gnt = 60; p_ready = 50; dly_min = 0; dly_max = 5;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 3) cycle(1, $urandom);
      else cycle(0, 0);
    end

    // Reset mid-transaction; the late rvalid must be ignored.
    p_gnt = 100; p_ready = 100; dly_min = 4; dly_max = 4;
    wait_outstanding("wait_rst_wait");
    p_gnt = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cycle(0, 0);
    #5;
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_occupancy", occupancy, 0);
    check("post_rst_req", imem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
